// File: rtl/jtag_pa.sv
// Shared JTAG types and the TAP next-state function used by both the target and the host mirror.
package jtag_pa;

   typedef enum logic [3:0] {
      STATE_RESET,
      STATE_IDLE,
      STATE_SELECT_DR,
      STATE_CAPTURE_DR,
      STATE_SHIFT_DR,
      STATE_EXIT1_DR,
      STATE_PAUSE_DR,
      STATE_EXIT2_DR,
      STATE_UPDATE_DR,
      STATE_SELECT_IR,
      STATE_CAPTURE_IR,
      STATE_SHIFT_IR,
      STATE_EXIT1_IR,
      STATE_PAUSE_IR,
      STATE_EXIT2_IR,
      STATE_UPDATE_IR
   } ty_STATE_TAP_FSM;

   typedef enum logic [1:0] {
      OP_RESET    = 2'd0,
      OP_SHIFT_IR = 2'd1,
      OP_SHIFT_DR = 2'd2,
      OP_IDLE     = 2'd3
   } ty_HOST_OP;

   typedef enum logic [1:0] {
      HOST_INIT,
      HOST_READY,
      HOST_RUN,
      HOST_RSP
   } ty_STATE_HOST_FSM;

   // Standard IEEE 1149.1 TAP controller transition on a TCK rising edge.
   function automatic ty_STATE_TAP_FSM f_tapNextState(input ty_STATE_TAP_FSM state, input logic tms);
      f_tapNextState = state;
      case (state)
         STATE_RESET:      f_tapNextState = tms ? STATE_RESET      : STATE_IDLE;
         STATE_IDLE:       f_tapNextState = tms ? STATE_SELECT_DR  : STATE_IDLE;
         STATE_SELECT_DR:  f_tapNextState = tms ? STATE_SELECT_IR  : STATE_CAPTURE_DR;
         STATE_CAPTURE_DR: f_tapNextState = tms ? STATE_EXIT1_DR   : STATE_SHIFT_DR;
         STATE_SHIFT_DR:   f_tapNextState = tms ? STATE_EXIT1_DR   : STATE_SHIFT_DR;
         STATE_EXIT1_DR:   f_tapNextState = tms ? STATE_UPDATE_DR  : STATE_PAUSE_DR;
         STATE_PAUSE_DR:   f_tapNextState = tms ? STATE_EXIT2_DR   : STATE_PAUSE_DR;
         STATE_EXIT2_DR:   f_tapNextState = tms ? STATE_UPDATE_DR  : STATE_SHIFT_DR;
         STATE_UPDATE_DR:  f_tapNextState = tms ? STATE_SELECT_DR  : STATE_IDLE;
         STATE_SELECT_IR:  f_tapNextState = tms ? STATE_RESET      : STATE_CAPTURE_IR;
         STATE_CAPTURE_IR: f_tapNextState = tms ? STATE_EXIT1_IR   : STATE_SHIFT_IR;
         STATE_SHIFT_IR:   f_tapNextState = tms ? STATE_EXIT1_IR   : STATE_SHIFT_IR;
         STATE_EXIT1_IR:   f_tapNextState = tms ? STATE_UPDATE_IR  : STATE_PAUSE_IR;
         STATE_PAUSE_IR:   f_tapNextState = tms ? STATE_EXIT2_IR   : STATE_PAUSE_IR;
         STATE_EXIT2_IR:   f_tapNextState = tms ? STATE_UPDATE_IR  : STATE_SHIFT_IR;
         STATE_UPDATE_IR:  f_tapNextState = tms ? STATE_SELECT_DR  : STATE_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/jtag_host.sv
// JTAG initiator: turns reset/IR/DR/idle commands into TMS/TDI sequences and returns captured TDO.
module jtag_host
   import jtag_pa::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
   input  logic              i_tclk,
   input  logic              i_trst_n,
   input  logic              i_cmdValid,
   output logic              o_cmdReady,
   input  logic [1:0]        i_cmdOp,
   input  logic [LEN_W-1:0]  i_cmdLen,
   input  logic [DATA_W-1:0] i_cmdData,
   output logic              o_rspValid,
   input  logic              i_rspReady,
   output logic [DATA_W-1:0] o_rspData,
   output logic              o_tms,
   output logic              o_tdi,
   input  logic              i_tdo
);

   // Longest sequence is an IR shift: 4 lead-in steps + DATA_W + 2 trailing steps.
   localparam int unsigned STEP_W = $clog2(DATA_W + 7);

   ty_STATE_HOST_FSM  hostState_q;
   ty_STATE_TAP_FSM   mirror_q;
   ty_STATE_TAP_FSM   mirrorNext;
   ty_HOST_OP         op_q;
   ty_HOST_OP         cmdOp;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cmdLenSat;
   logic [STEP_W-1:0] cmdTotal;
   logic [STEP_W-1:0] total_q;
   logic [STEP_W-1:0] step_q;
   logic [STEP_W-1:0] pre;
   logic [STEP_W-1:0] shiftEnd;
   logic [DATA_W-1:0] data_q;
   logic [LEN_W-1:0]  capIdx_q;
   logic              stepTms;
   logic              stepShift;
   logic              inShift;

   assign mirrorNext = f_tapNextState(mirror_q, o_tms);
   assign inShift    = (mirror_q == STATE_SHIFT_DR) || (mirror_q == STATE_SHIFT_IR);
   assign cmdLenSat  = (i_cmdLen > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : i_cmdLen;

   // Sequence length for the incoming command, counted from the accept edge.
   always_comb begin
      cmdOp    = ty_HOST_OP'(i_cmdOp);
      cmdTotal = STEP_W'(6);
      case (cmdOp)
         OP_SHIFT_IR: cmdTotal = STEP_W'(cmdLenSat) + STEP_W'(6);
         OP_SHIFT_DR: cmdTotal = STEP_W'(cmdLenSat) + STEP_W'(5);
         OP_IDLE:     cmdTotal = (cmdLenSat == '0) ? STEP_W'(1) : STEP_W'(cmdLenSat);
         default:     ;
      endcase
   end

   // TMS/TDI for step step_q; the capture step and the shift steps share the "last one exits" rule,
   // which makes a zero-length shift leave Capture straight for Exit1.
   always_comb begin
      stepTms   = 1'b0;
      stepShift = 1'b0;
      pre       = (op_q == OP_SHIFT_IR) ? STEP_W'(4) : STEP_W'(3);
      shiftEnd  = pre + STEP_W'(len_q);
      case (op_q)
         OP_RESET: stepTms = (step_q < STEP_W'(5));
         OP_IDLE:  ;
         default: begin
            if (step_q + STEP_W'(1) < pre) begin
               stepTms = (step_q == '0) || ((op_q == OP_SHIFT_IR) && (step_q == STEP_W'(1)));
            end else if (step_q < shiftEnd) begin
               stepTms   = (step_q + STEP_W'(1) == shiftEnd);
               stepShift = (step_q >= pre);
            end else begin
               stepTms = (step_q == shiftEnd);
            end
         end
      endcase
   end

   always_ff @(posedge i_tclk or negedge i_trst_n) begin
      if (!i_trst_n) begin
         hostState_q <= HOST_INIT;
         mirror_q    <= STATE_RESET;
         o_tms       <= 1'b1;
         o_tdi       <= 1'b0;
         o_cmdReady  <= 1'b0;
         o_rspValid  <= 1'b0;
         o_rspData   <= '0;
         op_q        <= OP_IDLE;
         len_q       <= '0;
         total_q     <= '0;
         step_q      <= '0;
         data_q      <= '0;
         capIdx_q    <= '0;
      end else begin
         mirror_q <= mirrorNext;

         if (inShift && (hostState_q == HOST_RUN)) begin
            o_rspData <= o_rspData | (DATA_W'(i_tdo) << capIdx_q);
            capIdx_q  <= capIdx_q + LEN_W'(1);
         end

         case (hostState_q)
            HOST_INIT: begin
               o_tms <= 1'b0;
               o_tdi <= 1'b0;
               if (mirrorNext == STATE_IDLE) begin
                  hostState_q <= HOST_READY;
                  o_cmdReady  <= 1'b1;
               end
            end

            HOST_READY: begin
               o_tms <= 1'b0;
               o_tdi <= 1'b0;
               if (i_cmdValid) begin
                  op_q        <= cmdOp;
                  len_q       <= cmdLenSat;
                  total_q     <= cmdTotal;
                  step_q      <= STEP_W'(1);
                  data_q      <= i_cmdData;
                  capIdx_q    <= '0;
                  o_rspData   <= '0;
                  o_tms       <= (cmdOp != OP_IDLE);
                  o_cmdReady  <= 1'b0;
                  hostState_q <= HOST_RUN;
               end
            end

            HOST_RUN: begin
               if (step_q == total_q) begin
                  hostState_q <= HOST_RSP;
                  o_rspValid  <= 1'b1;
                  o_tms       <= 1'b0;
                  o_tdi       <= 1'b0;
               end else begin
                  o_tms  <= stepTms;
                  o_tdi  <= stepShift & data_q[0];
                  step_q <= step_q + STEP_W'(1);
                  if (stepShift) begin
                     data_q <= data_q >> 1;
                  end
               end
            end

            HOST_RSP: begin
               o_tms <= 1'b0;
               o_tdi <= 1'b0;
               if (i_rspReady) begin
                  o_rspValid  <= 1'b0;
                  o_cmdReady  <= 1'b1;
                  hostState_q <= HOST_READY;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_host.sv
// Randomized scoreboard bench for jtag_host driving a behavioural TAP target (4-bit IR, 32-bit DR).
module tb_jtag_host;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LEN_W  = 6;
   localparam logic [31:0] DR_CAP = 32'h1234_5677;
   localparam logic [3:0]  IR_CAP = 4'b0001;

   localparam int T_RESET = 0,  T_IDLE = 1,   T_SELDR = 2,  T_CAPDR = 3;
   localparam int T_SHDR  = 4,  T_EX1DR = 5,  T_PSDR = 6,   T_EX2DR = 7;
   localparam int T_UPDR  = 8,  T_SELIR = 9,  T_CAPIR = 10, T_SHIR = 11;
   localparam int T_EX1IR = 12, T_PSIR = 13,  T_EX2IR = 14, T_UPIR = 15;

   logic              i_tclk;
   logic              i_trst_n;
   logic              i_cmdValid;
   logic              o_cmdReady;
   logic [1:0]        i_cmdOp;
   logic [LEN_W-1:0]  i_cmdLen;
   logic [DATA_W-1:0] i_cmdData;
   logic              o_rspValid;
   logic              i_rspReady;
   logic [DATA_W-1:0] o_rspData;
   logic              o_tms;
   logic              o_tdi;
   logic              i_tdo;

   jtag_host #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .i_tclk(i_tclk), .i_trst_n(i_trst_n),
      .i_cmdValid(i_cmdValid), .o_cmdReady(o_cmdReady),
      .i_cmdOp(i_cmdOp), .i_cmdLen(i_cmdLen), .i_cmdData(i_cmdData),
      .o_rspValid(o_rspValid), .i_rspReady(i_rspReady), .o_rspData(o_rspData),
      .o_tms(o_tms), .o_tdi(o_tdi), .i_tdo(i_tdo)
   );

   initial i_tclk = 1'b0;
   always #5 i_tclk = ~i_tclk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge i_tclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural TAP target ----------------
   function automatic int tapNext(input int s, input logic tms);
      case (s)
         T_RESET: return tms ? T_RESET : T_IDLE;
         T_IDLE:  return tms ? T_SELDR : T_IDLE;
         T_SELDR: return tms ? T_SELIR : T_CAPDR;
         T_CAPDR: return tms ? T_EX1DR : T_SHDR;
         T_SHDR:  return tms ? T_EX1DR : T_SHDR;
         T_EX1DR: return tms ? T_UPDR  : T_PSDR;
         T_PSDR:  return tms ? T_EX2DR : T_PSDR;
         T_EX2DR: return tms ? T_UPDR  : T_SHDR;
         T_UPDR:  return tms ? T_SELDR : T_IDLE;
         T_SELIR: return tms ? T_RESET : T_CAPIR;
         T_CAPIR: return tms ? T_EX1IR : T_SHIR;
         T_SHIR:  return tms ? T_EX1IR : T_SHIR;
         T_EX1IR: return tms ? T_UPIR  : T_PSIR;
         T_PSIR:  return tms ? T_EX2IR : T_PSIR;
         T_EX2IR: return tms ? T_UPIR  : T_SHIR;
         default: return tms ? T_SELDR : T_IDLE;
      endcase
   endfunction

   int          tapSt = T_RESET;
   int          shiftEdges = 0;
   logic [3:0]  irSr = '0, irReg = '0;
   logic [31:0] drSr = '0, drReg = '0;

   always @(posedge i_tclk or negedge i_trst_n) begin
      if (!i_trst_n) begin
         tapSt <= T_RESET;
      end else begin
         tapSt <= tapNext(tapSt, o_tms);
         case (tapSt)
            T_CAPDR: drSr <= DR_CAP;
            T_SHDR:  begin drSr <= {o_tdi, drSr[31:1]}; shiftEdges <= shiftEdges + 1; end
            T_UPDR:  drReg <= drSr;
            T_CAPIR: irSr <= IR_CAP;
            T_SHIR:  begin irSr <= {o_tdi, irSr[3:1]}; shiftEdges <= shiftEdges + 1; end
            T_UPIR:  irReg <= irSr;
            default: ;
         endcase
      end
   end

   assign i_tdo = (tapSt == T_SHDR) ? drSr[0] : (tapSt == T_SHIR) ? irSr[0] : 1'b0;

   // ---------------- reference model ----------------
   function automatic int satLen(input int len);
      return (len > 32) ? 32 : len;
   endfunction

   function automatic int expLat(input int op, input int len);
      int n = satLen(len);
      case (op)
         0:       return 6;
         1:       return n + 6;
         2:       return n + 5;
         default: return (n == 0) ? 1 : n;
      endcase
   endfunction

   // TDO stream seen by the host is the capture value followed by the bits shifted in.
   function automatic logic [63:0] stream(input int op, input logic [31:0] data);
      logic [63:0] s;
      if (op == 2) s = {data, DR_CAP};
      else         s = {28'h0, data, IR_CAP};
      return s;
   endfunction

   function automatic logic [31:0] expRsp(input int op, input int len, input logic [31:0] data);
      int n = satLen(len);
      logic [63:0] mask;
      if (op == 0 || op == 3) return 32'h0;
      mask = (64'd1 << n) - 64'd1;
      return 32'(stream(op, data) & mask);
   endfunction

   // ---------------- scoreboard monitor ----------------
   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t expQ[$];
   bit   inRsp = 1'b0;

   always @(negedge i_tclk) begin
      exp_t e;
      if (o_rspValid) begin
         chk("rsp_blocks_cmdready", 64'(o_cmdReady), 64'd0);
         chk("rsp_tms_low", 64'(o_tms), 64'd0);
         chk("rsp_target_idle", 64'(tapSt), 64'(T_IDLE));
         if (!inRsp) begin
            inRsp = 1'b1;
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rsp: got data %0h expected no response", o_rspData);
            end else begin
               e = expQ.pop_front();
               chk("rsp_data", 64'(o_rspData), 64'(e.data));
               chk("rsp_latency", 64'(cyc), 64'(e.cyc));
            end
         end
      end else begin
         inRsp = 1'b0;
      end
   end

   // Response-ready driver: 0 always ready, 1 random backpressure, 2 held low.
   int rdyMode = 0;
   always @(negedge i_tclk) begin
      if (rdyMode == 0)      i_rspReady = 1'b1;
      else if (rdyMode == 1) i_rspReady = ($urandom_range(0, 3) != 0);
      else                   i_rspReady = 1'b0;
   end

   // ---------------- stimulus ----------------
   task automatic waitReady(input string name);
      int n = 0;
      @(negedge i_tclk);
      while (!o_cmdReady && n < 300) begin
         @(negedge i_tclk);
         n++;
      end
      if (!o_cmdReady) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got cmdReady 0 expected 1 within 300 cycles", name);
      end
   endtask

   task automatic sendCmd(input int op, input int len, input logic [31:0] data,
                          input bit expectRsp, output int shiftBase);
      waitReady("cmd_ready");
      i_cmdValid = 1'b1;
      i_cmdOp    = 2'(op);
      i_cmdLen   = LEN_W'(len);
      i_cmdData  = data;
      shiftBase  = shiftEdges;
      @(posedge i_tclk);
      @(negedge i_tclk);
      i_cmdValid = 1'b0;
      i_cmdOp    = 2'($urandom);
      i_cmdLen   = LEN_W'($urandom);
      i_cmdData  = $urandom;
      if (expectRsp) expQ.push_back('{data: expRsp(op, len, data), cyc: cyc + expLat(op, len)});
   endtask

   task automatic runCmd(input int op, input int len, input logic [31:0] data);
      int base;
      sendCmd(op, len, data, 1'b1, base);
      waitReady("rsp_done");
      chk("target_idle_after", 64'(tapSt), 64'(T_IDLE));
      if (op == 1 || op == 2)
         chk("shift_edges", 64'(shiftEdges - base), 64'(satLen(len)));
      if (op == 1)
         chk("target_ir", 64'(irReg), 64'(4'(stream(op, data) >> satLen(len))));
      if (op == 2)
         chk("target_dr", 64'(drReg), 64'(32'(stream(op, data) >> satLen(len))));
   endtask

   task automatic checkResetValues(input string tag);
      chk({tag, "_tms"}, 64'(o_tms), 64'd1);
      chk({tag, "_tdi"}, 64'(o_tdi), 64'd0);
      chk({tag, "_cmdready"}, 64'(o_cmdReady), 64'd0);
      chk({tag, "_rspvalid"}, 64'(o_rspValid), 64'd0);
      chk({tag, "_rspdata"}, 64'(o_rspData), 64'd0);
      chk({tag, "_target"}, 64'(tapSt), 64'(T_RESET));
   endtask

   task automatic checkInitWalk(input string tag);
      @(negedge i_tclk);
      chk({tag, "_e1_ready"}, 64'(o_cmdReady), 64'd0);
      chk({tag, "_e1_tms"}, 64'(o_tms), 64'd0);
      chk({tag, "_e1_target"}, 64'(tapSt), 64'(T_RESET));
      @(negedge i_tclk);
      chk({tag, "_e2_ready"}, 64'(o_cmdReady), 64'd1);
      chk({tag, "_e2_target"}, 64'(tapSt), 64'(T_IDLE));
   endtask

   initial begin
      int base;
      int n;
      i_trst_n   = 1'b0;
      i_cmdValid = 1'b0;
      i_cmdOp    = '0;
      i_cmdLen   = '0;
      i_cmdData  = '0;
      i_rspReady = 1'b1;
      repeat (3) @(negedge i_tclk);
      checkResetValues("reset");
      i_trst_n = 1'b1;
      checkInitWalk("init");

      runCmd(1, 4, 32'h0000_000A);
      runCmd(2, 32, 32'hDEAD_BEEF);
      runCmd(2, 0, 32'h5555_AAAA);
      runCmd(2, 40, 32'hCAFE_F00D);
      runCmd(1, 0, 32'h0000_0003);
      runCmd(3, 0, 32'hFFFF_FFFF);
      runCmd(3, 7, 32'h0);

      // Response held off: valid must persist and the command side stays closed.
      rdyMode = 2;
      sendCmd(0, 0, 32'h0, 1'b1, base);
      n = 0;
      while (!o_rspValid && n < 50) begin
         @(negedge i_tclk);
         n++;
      end
      repeat (5) begin
         chk("hold_valid", 64'(o_rspValid), 64'd1);
         chk("hold_cmdready", 64'(o_cmdReady), 64'd0);
         chk("hold_tms", 64'(o_tms), 64'd0);
         @(negedge i_tclk);
      end
      rdyMode = 0;
      waitReady("hold_release");

      rdyMode = 1;
      repeat (30) runCmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)), $urandom);
      rdyMode = 0;

      // Reset in the middle of a 32-bit DR shift, after shift step 10 is on the pins.
      sendCmd(2, 32, $urandom, 1'b0, base);
      repeat (13) @(negedge i_tclk);
      chk("pre_reset_shift_edges", 64'(shiftEdges - base), 64'd10);
      i_trst_n = 1'b0;
      #1;
      checkResetValues("midcmd");
      @(negedge i_tclk);
      i_trst_n = 1'b1;
      checkInitWalk("rewalk");
      runCmd(2, 16, 32'h0000_BEEF);
      repeat (10) @(negedge i_tclk);

      chk("queue_empty", 64'(expQ.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
